// File: rtl/gen_clk_mon.sv
// gen_clk_mon: measures the period of a slow asynchronous clock in iclk cycles and
// flags a stall when no rising edge arrives for TIMEOUT cycles. GEN_CLK_MON_DUTY_EN adds high-time measurement.
module gen_clk_mon #(
  parameter logic [31:0] TIMEOUT = 32'h02FAF080
) (
  input  logic        iclk,
  input  logic        rst,
  input  logic        sclk,
  output logic        tick,
  output logic        valid,
  output logic [31:0] period,
  output logic [31:0] high_time,
  output logic        stalled
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } state_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0]  smp_vld_q, smp_vld_d;
  logic        armed_q, armed_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_q, period_d;
  logic        tick_q, tick_d;
  logic        valid_q, valid_d;
  logic        stalled_q, stalled_d;
  logic        rise;

  // A rise needs a genuinely sampled low first; reset zeros in s2/s3 do not count.
  assign rise = s2_q & ~s3_q & armed_q;

  // Synchronizer, cycle counter and measurement state machine next-state logic
  always_comb begin
    s1_d      = sclk;
    s2_d      = s1_q;
    s3_d      = s2_q;
    smp_vld_d = {smp_vld_q[0], 1'b1};
    armed_d   = armed_q | (smp_vld_q[1] & ~s2_q);

    if (rise) begin
      cnt_d = 32'd1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end

    tick_d   = rise;
    valid_d  = 1'b0;
    period_d = period_q;
    state_d  = state_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
        end else if (cnt_q == TIMEOUT) begin
          state_d = STALL;
        end else begin
          state_d = IDLE;
        end
      end
      MEASURE: begin
        if (rise) begin
          valid_d  = 1'b1;
          period_d = cnt_q;
          state_d  = MEASURE;
        end else if (cnt_q == TIMEOUT) begin
          state_d = STALL;
        end else begin
          state_d = MEASURE;
        end
      end
      STALL: begin
        if (rise) begin
          state_d = MEASURE;
        end else begin
          state_d = STALL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    stalled_d = (state_d == STALL);
  end

`ifdef GEN_CLK_MON_DUTY_EN
  logic        fall;
  logic [31:0] hcnt_q, hcnt_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] high_q, high_d;

  assign fall = ~s2_q & s3_q;

  // High-time counter, latched on fall and published alongside period
  always_comb begin
    if (rise) begin
      hcnt_d = 32'd1;
    end else if (s2_q && (hcnt_q != CNT_MAX)) begin
      hcnt_d = hcnt_q + 32'd1;
    end else begin
      hcnt_d = hcnt_q;
    end
    if (fall) begin
      pend_d = hcnt_q;
    end else begin
      pend_d = pend_q;
    end
    if (valid_d) begin
      high_d = pend_q;
    end else begin
      high_d = high_q;
    end
  end

  assign high_time = high_q;
`else
  assign high_time = 32'h0000_0000;
`endif

  // All state, with synchronous reset overriding every other event
  always_ff @(posedge iclk) begin
    if (rst) begin
      state_q   <= IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      smp_vld_q <= 2'b00;
      armed_q   <= 1'b0;
      cnt_q     <= 32'd0;
      period_q  <= 32'd0;
      tick_q    <= 1'b0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
`ifdef GEN_CLK_MON_DUTY_EN
      hcnt_q    <= 32'd0;
      pend_q    <= 32'd0;
      high_q    <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      smp_vld_q <= smp_vld_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      tick_q    <= tick_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
`ifdef GEN_CLK_MON_DUTY_EN
      hcnt_q    <= hcnt_d;
      pend_q    <= pend_d;
      high_q    <= high_d;
`endif
    end
  end

  assign tick    = tick_q;
  assign valid   = valid_q;
  assign period  = period_q;
  assign stalled = stalled_q;

endmodule

// File: tb/tb_gen_clk_mon.sv
// tb_gen_clk_mon: directed vectors for gen_clk_mon with TIMEOUT = 100.
module tb_gen_clk_mon;

  localparam logic [31:0] TMO = 32'd100;
`ifdef GEN_CLK_MON_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic        iclk = 1'b0;
  logic        rst  = 1'b0;
  logic        sclk = 1'b0;
  logic        tick, valid, stalled;
  logic [31:0] period, high_time;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    int hi;
    int lo;
    bit ev;
    int ep;
    int eh;
  } vec_t;

  vec_t vecs[6];

  gen_clk_mon #(.TIMEOUT(TMO)) dut (
    .iclk      (iclk),
    .rst       (rst),
    .sclk      (sclk),
    .tick      (tick),
    .valid     (valid),
    .period    (period),
    .high_time (high_time),
    .stalled   (stalled)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One sclk period: high for hi samples then low for lo cycles; checks the tick cycle.
  task automatic sclk_edge(input int hi, input int lo, input bit ev, input int ep,
                           input int eh, input string tag);
    sclk = 1'b1;
    repeat (2) @(posedge iclk);
    #1;
    check({tag, " early tick"}, {31'd0, tick}, 32'd0);
    @(posedge iclk);
    #1;
    check({tag, " tick"}, {31'd0, tick}, 32'd1);
    check({tag, " valid"}, {31'd0, valid}, {31'd0, ev});
    check({tag, " period"}, period, ep);
    check({tag, " high_time"}, high_time, DUTY ? eh : 0);
    check({tag, " stalled"}, {31'd0, stalled}, 32'd0);
    repeat (hi - 3) @(posedge iclk);
    #1;
    sclk = 1'b0;
    repeat (lo) @(posedge iclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " tick"}, {31'd0, tick}, 32'd0);
    check({tag, " valid"}, {31'd0, valid}, 32'd0);
    check({tag, " period"}, period, 32'd0);
    check({tag, " high_time"}, high_time, 32'd0);
    check({tag, " stalled"}, {31'd0, stalled}, 32'd0);
  endtask

  initial begin
    bit tick_seen;

    vecs[0] = '{8, 12, 1'b0, 0, 0};
    vecs[1] = '{8, 12, 1'b1, 20, 8};
    vecs[2] = '{8, 12, 1'b1, 20, 8};
    vecs[3] = '{10, 20, 1'b1, 20, 8};
    vecs[4] = '{10, 20, 1'b1, 30, 10};
    vecs[5] = '{10, 20, 1'b1, 30, 10};

    rst = 1'b1;
    repeat (3) @(posedge iclk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (5) @(posedge iclk);
    #1;

    for (int i = 0; i < 6; i++) begin
      sclk_edge(vecs[i].hi, vecs[i].lo, vecs[i].ev, vecs[i].ep, vecs[i].eh,
                $sformatf("vec%0d", i));
    end

    // Stall: tick of B, then hold low until stalled rises 100 cycles later.
    sclk_edge(8, 12, 1'b1, 30, 10, "A");
    sclk_edge(8, 0, 1'b1, 20, 8, "B");
    repeat (94) @(posedge iclk);
    #1;
    check("stall early", {31'd0, stalled}, 32'd0);
    @(posedge iclk);
    #1;
    check("stall set", {31'd0, stalled}, 32'd1);
    check("stall period", period, 32'd20);
    sclk_edge(8, 17, 1'b0, 20, 8, "C");
    sclk_edge(8, 12, 1'b1, 25, 8, "D");

    // Rise coinciding with cnt == TIMEOUT must not stall.
    sclk_edge(8, 92, 1'b1, 20, 8, "H");
    sclk_edge(8, 12, 1'b1, 100, 8, "I");

    // Mid-period reset discards the partial measurement.
    sclk_edge(8, 0, 1'b1, 20, 8, "E");
    repeat (4) @(posedge iclk);
    #1;
    rst = 1'b1;
    @(posedge iclk);
    #1;
    rst = 1'b0;
    check_all_zero("midrst");
    repeat (10) @(posedge iclk);
    #1;
    sclk_edge(8, 12, 1'b0, 0, 0, "F");
    sclk_edge(8, 12, 1'b1, 20, 8, "G");

    // sclk high across reset release: no tick, stall after TIMEOUT.
    sclk = 1'b1;
    repeat (5) @(posedge iclk);
    #1;
    rst = 1'b1;
    @(posedge iclk);
    #1;
    rst = 1'b0;
    check("hold rst stalled", {31'd0, stalled}, 32'd0);
    tick_seen = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      @(posedge iclk);
      #1;
      tick_seen = tick_seen | tick;
      if (k == 99) check("hold stalled early", {31'd0, stalled}, 32'd0);
      if (k == 101) check("hold stalled set", {31'd0, stalled}, 32'd1);
    end
    check("hold no tick", {31'd0, tick_seen}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gen_clk_mon.md
GEN_CLK_MON -- requirements
Module: gen_clk_mon

Interface
REQ-001 Parameter TIMEOUT, default 32'h02FAF080, no-edge limit in iclk cycles (1 s at 50 MHz, i.e. two 2 Hz periods).
REQ-002 iclk  input  1  system clock, 50 MHz; all logic on posedge iclk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sclk  input  1  monitored slow clock (nominal 2 Hz); asynchronous to iclk.
REQ-005 tick  output  1  one-cycle pulse per synchronized sclk rising edge.
REQ-006 valid  output  1  one-cycle pulse when period (and high_time) are updated.
REQ-007 period  output  32  last measured sclk period, in iclk cycles.
REQ-008 high_time  output  32  last measured sclk high time, in iclk cycles.
REQ-009 stalled  output  1  level; no sclk rising edge seen for TIMEOUT cycles.

Function
REQ-010 sclk SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3.
REQ-011 Rising edge (rise) SHALL be s2 & ~s3; falling edge (fall) SHALL be ~s2 & s3.
REQ-012 tick SHALL be registered and SHALL assert on the 3rd posedge iclk after the first posedge that samples sclk high.
REQ-013 Cycle counter cnt (32 bit) SHALL load 1 on rise and otherwise increment by 1, saturating at 32'hFFFFFFFF.
REQ-014 State machine states: IDLE, MEASURE, STALL.
REQ-015 IDLE: rise -> MEASURE with no valid. cnt == TIMEOUT -> STALL.
REQ-016 MEASURE: rise -> period <= cnt, valid pulses in the same cycle as tick, stay in MEASURE. cnt == TIMEOUT -> STALL.
REQ-017 STALL: stalled = 1 while in STALL. rise -> MEASURE and stalled clears on the tick cycle, with no valid.
REQ-018 period SHALL equal the number of iclk cycles between two consecutive tick pulses.
REQ-019 period and high_time SHALL hold their last values through IDLE-to-MEASURE and STALL transitions.
REQ-020 A rise and a cnt == TIMEOUT in the same cycle SHALL resolve in favour of rise (no STALL entry).
REQ-021 valid SHALL never assert without tick in the same cycle; tick MAY assert without valid.

Reset
REQ-022 When rst = 1 at posedge iclk, the block SHALL clear s1, s2, s3, cnt, period, high_time, tick, valid and stalled to 0 and SHALL enter IDLE.
REQ-023 rst SHALL override all other events; an assertion mid-measurement SHALL discard the partial count, so the first rise after reset produces no valid.
REQ-024 If sclk is high when rst deasserts, that level SHALL NOT be treated as a rise; a rise SHALL require a sampled low first.

Configuration
REQ-025 Macro GEN_CLK_MON_DUTY_EN SHALL enable high-time measurement.
REQ-026 With the macro defined:
- hcnt SHALL load 1 on rise and increment while s2 = 1.
- On fall, hcnt SHALL latch into a pending register.
- The pending value SHALL be published to high_time together with period on valid.
REQ-027 Without the macro, high_time SHALL be tied to 32'h0 and no hcnt or pending logic SHALL exist. All other behaviour SHALL be unchanged.

Verification (bench uses TIMEOUT = 100)
REQ-028 Reset, then sclk period 20 cycles with high time 8, three rising edges:
- first tick: valid = 0.
- second and third ticks: valid = 1, period = 20, high_time = 8 (macro on) or 0 (macro off).
REQ-029 Period change from 20 to 30 cycles: the first valid that spans a 30-cycle interval SHALL show period = 30. stalled SHALL stay 0 throughout.
REQ-030 After period = 20 is established, hold sclk low:
- stalled SHALL rise 100 cycles after the last tick, and period SHALL stay 20.
- the next edge SHALL give tick = 1, valid = 0, stalled = 0.
- the following edge SHALL give valid with the new period.
REQ-031 Assert rst for 1 cycle mid-period: all outputs SHALL be 0 the next cycle. The next rise SHALL give tick without valid, and the rise after it SHALL give valid.
REQ-032 sclk held high from before reset release: tick SHALL never assert, and stalled = 1 SHALL be reached after 100 cycles.
